// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// Module      : reg_bank_pkg
// Description : Shared constants and helper function for the register bank.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package reg_bank_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 4;

  // Index width for n entries; never narrower than one bit.
  function automatic int addr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_if.sv
// ---------------------------------------------------------------------------
// Module      : reg_bank_if
// Description : Write, read and output-channel signals of the register bank.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface reg_bank_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 2
);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_stall;
  logic [AW-1:0]     rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [AW-1:0]     rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Producer / consumer side of the bank
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, out_ready,
    input  wr_stall, rd_data_a, rd_data_b, out_data, out_valid
  );

  // The bank itself
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, out_ready,
    output wr_stall, rd_data_a, rd_data_b, out_data, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/reg_cell.sv
// ---------------------------------------------------------------------------
// Module      : reg_cell
// Description : One storage word with write enable, reset and clear.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_cell #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  input  wire logic              clr,
  input  wire logic              i_we,
  input  wire logic [DATA_W-1:0] i_d,
  output      logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Storage word: reset beats clear beats write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// Module      : reg_bank
// Description : NUM_REGS x DATA_W register bank, one write port, two
//               combinational read ports with optional write-through bypass,
//               and a valid/ready output channel fed by register OUT_IDX.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int OUT_IDX  = NUM_REGS - 1,
  parameter int BYPASS   = 1
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  input  wire logic   clr,
  reg_bank_if.slave   bus
);

  localparam int            AW         = addr_width(NUM_REGS);
  localparam logic [AW-1:0] c_OUT_IDX  = AW'(OUT_IDX);
  localparam logic [AW:0]   c_NUM_REGS = (AW+1)'(NUM_REGS);

  logic [DATA_W-1:0] w_q [NUM_REGS];
  logic [NUM_REGS-1:0] w_we;
  logic              w_addr_valid;
  logic              w_wr_out;
  logic              w_wr_stall;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              r_out_valid;

  // Non-power-of-two banks leave holes in the index space that must be ignored.
  assign w_addr_valid = ({1'b0, bus.wr_addr} < c_NUM_REGS);
  assign w_wr_out     = bus.wr_en && (bus.wr_addr == c_OUT_IDX);
  assign w_wr_stall   = w_wr_out && r_out_valid && !bus.out_ready;
  assign w_wr_acc     = bus.wr_en && w_addr_valid && !w_wr_stall && rstn && !clr;

  // One-hot write enable per storage word
  always_comb begin
    w_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_we[i] = w_wr_acc && (bus.wr_addr == AW'(i));
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cells
      reg_cell #(
        .DATA_W (DATA_W)
      ) u_cell (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .i_we (w_we[gi]),
        .i_d  (bus.wr_data),
        .o_q  (w_q[gi])
      );
    end
  endgenerate

  // Read muxes; holes in the index space read as zero, bypass wins on a hit
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_a == AW'(i)) w_rd_a = w_q[i];
      if (bus.rd_addr_b == AW'(i)) w_rd_b = w_q[i];
    end
    if ((BYPASS != 0) && w_wr_acc) begin
      if (bus.rd_addr_a == bus.wr_addr) w_rd_a = bus.wr_data;
      if (bus.rd_addr_b == bus.wr_addr) w_rd_b = bus.wr_data;
    end
  end

  // Output-channel valid: a new word outranks the consume, so a same-cycle
  // handshake plus write keeps valid high for full throughput
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
    end else if (w_wr_acc && (bus.wr_addr == c_OUT_IDX)) begin
      r_out_valid <= 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.wr_stall  = w_wr_stall;
  assign bus.rd_data_a = w_rd_a;
  assign bus.rd_data_b = w_rd_b;
  assign bus.out_data  = w_q[OUT_IDX];
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ---------------------------------------------------------------------------
// Module      : tb_reg_bank
// Description : Directed, table-driven bench for reg_bank (5 regs, OUT_IDX 4).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_bank;

  logic clk;
  logic rstn;
  logic clr;

  reg_bank_if #(.DATA_W(8), .AW(3)) bus ();

  reg_bank #(
    .DATA_W   (8),
    .NUM_REGS (5),
    .OUT_IDX  (4),
    .BYPASS   (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       cl;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       rdy;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       est;
    logic       eov;
    logic [7:0] eod;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  logic [7:0] mdl [8];

  int n_vec;
  int n_bad;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, settle, leave the rising edge to follow
  task automatic apply(input logic rs, input logic cl, input logic we,
                       input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic rdy);
    @(negedge clk);
    rstn          = rs;
    clr           = cl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic est, input logic eov, input logic [7:0] eod);
    chk({tag, " rd_data_a"}, bus.rd_data_a, ea);
    chk({tag, " rd_data_b"}, bus.rd_data_b, eb);
    chk({tag, " wr_stall"},  {7'd0, bus.wr_stall}, {7'd0, est});
    chk({tag, " out_valid"}, {7'd0, bus.out_valid}, {7'd0, eov});
    chk({tag, " out_data"},  bus.out_data, eod);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rstn = 1'b0; clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.out_ready = 1'b0;

    //          rs   cl   we   wa    wd     ra    rb    rdy   ea     eb     st   ov   od
    // reset held with a write pending
    vecs[0]  = '{1'b0,1'b0,1'b1,3'd0,8'hFF,3'd0,3'd1,1'b0, 8'h00,8'h00,1'b0,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b0,1'b1,3'd4,8'hFF,3'd4,3'd4,1'b0, 8'h00,8'h00,1'b0,1'b0,8'h00};
    // basic write / read, bypass
    vecs[2]  = '{1'b1,1'b0,1'b1,3'd0,8'h3C,3'd1,3'd2,1'b0, 8'h00,8'h00,1'b0,1'b0,8'h00};
    vecs[3]  = '{1'b1,1'b0,1'b1,3'd1,8'hA5,3'd0,3'd2,1'b0, 8'h3C,8'h00,1'b0,1'b0,8'h00};
    vecs[4]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd0,3'd1,1'b0, 8'h3C,8'hA5,1'b0,1'b0,8'h00};
    vecs[5]  = '{1'b1,1'b0,1'b1,3'd0,8'h77,3'd0,3'd1,1'b0, 8'h77,8'hA5,1'b0,1'b0,8'h00};
    vecs[6]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd0,3'd0,1'b0, 8'h77,8'h77,1'b0,1'b0,8'h00};
    // output backpressure
    vecs[7]  = '{1'b1,1'b0,1'b1,3'd4,8'h11,3'd4,3'd0,1'b0, 8'h11,8'h77,1'b0,1'b0,8'h00};
    vecs[8]  = '{1'b1,1'b0,1'b1,3'd4,8'h22,3'd4,3'd1,1'b0, 8'h11,8'hA5,1'b1,1'b1,8'h11};
    vecs[9]  = '{1'b1,1'b0,1'b1,3'd4,8'h22,3'd3,3'd3,1'b0, 8'h00,8'h00,1'b1,1'b1,8'h11};
    vecs[10] = '{1'b1,1'b0,1'b1,3'd2,8'h5A,3'd2,3'd4,1'b0, 8'h5A,8'h11,1'b0,1'b1,8'h11};
    vecs[11] = '{1'b1,1'b0,1'b0,3'd4,8'h22,3'd4,3'd2,1'b1, 8'h11,8'h5A,1'b0,1'b1,8'h11};
    vecs[12] = '{1'b1,1'b0,1'b1,3'd4,8'h22,3'd0,3'd1,1'b0, 8'h77,8'hA5,1'b0,1'b0,8'h11};
    vecs[13] = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd4,3'd4,1'b0, 8'h22,8'h22,1'b0,1'b1,8'h22};
    // back-to-back with consumer always ready
    vecs[14] = '{1'b1,1'b0,1'b1,3'd4,8'h01,3'd0,3'd2,1'b1, 8'h77,8'h5A,1'b0,1'b1,8'h22};
    vecs[15] = '{1'b1,1'b0,1'b1,3'd4,8'h02,3'd0,3'd2,1'b1, 8'h77,8'h5A,1'b0,1'b1,8'h01};
    vecs[16] = '{1'b1,1'b0,1'b1,3'd4,8'h03,3'd0,3'd2,1'b1, 8'h77,8'h5A,1'b0,1'b1,8'h02};
    vecs[17] = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd0,3'd2,1'b1, 8'h77,8'h5A,1'b0,1'b1,8'h03};
    // ready while not valid is harmless
    vecs[18] = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd0,3'd2,1'b1, 8'h77,8'h5A,1'b0,1'b0,8'h03};
    vecs[19] = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd4,3'd4,1'b0, 8'h03,8'h03,1'b0,1'b0,8'h03};

    // One unchecked reset cycle to get the bank out of X
    apply(1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rs, vecs[i].cl, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].ra, vecs[i].rb, vecs[i].rdy);
      check_all($sformatf("v%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].est,
                vecs[i].eov, vecs[i].eod);
    end

    // Write to a hole in the index space: ignored, reads of holes give 0
    apply(1'b1, 1'b0, 1'b1, 3'd6, 8'hEE, 3'd6, 3'd5, 1'b0);
    check_all("inv_wr", 8'h00, 8'h00, 1'b0, 1'b0, 8'h03);
    mdl[0] = 8'h77; mdl[1] = 8'hA5; mdl[2] = 8'h5A; mdl[3] = 8'h00;
    mdl[4] = 8'h03; mdl[5] = 8'h00; mdl[6] = 8'h00; mdl[7] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
      chk($sformatf("inv_rb%0d a", i), bus.rd_data_a, mdl[i]);
      chk($sformatf("inv_rb%0d b", i), bus.rd_data_b, mdl[7 - i]);
    end

    // clr with a write in the same cycle drops the write and clears everything
    apply(1'b1, 1'b0, 1'b1, 3'd4, 8'hC3, 3'd0, 3'd0, 1'b0);
    check_all("pre_clr", 8'h77, 8'h77, 1'b0, 1'b0, 8'h03);
    apply(1'b1, 1'b1, 1'b1, 3'd2, 8'h99, 3'd2, 3'd4, 1'b0);
    check_all("clr", 8'h5A, 8'hC3, 1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
      chk($sformatf("clr_rb%0d a", i), bus.rd_data_a, 8'h00);
      chk($sformatf("clr_rb%0d b", i), bus.rd_data_b, 8'h00);
      if (i == 0) begin
        chk("clr out_valid", {7'd0, bus.out_valid}, 8'h00);
        chk("clr out_data", bus.out_data, 8'h00);
      end
    end

    // Reset while a word is pending discards it
    apply(1'b1, 1'b0, 1'b1, 3'd1, 8'h66, 3'd1, 3'd4, 1'b0);
    check_all("mr_w1", 8'h66, 8'h00, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 1'b1, 3'd4, 8'h5E, 3'd1, 3'd4, 1'b0);
    check_all("mr_w4", 8'h66, 8'h5E, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd1, 1'b0);
    check_all("mr_rst", 8'h5E, 8'h66, 1'b0, 1'b1, 8'h5E);
    apply(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd1, 1'b0);
    check_all("mr_post", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
